// File: rtl/risc_pkg.sv
// Shared definitions for the RISC memory arbiter: widths, FSM encoding, port ids.
package risc_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2,
        WR      = 2'd3
    } mem_arb_state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT_I = 1'b0;
    localparam port_id_t PORT_D = 1'b1;

endpackage

// File: rtl/risc_mem_arbiter_if.sv
// Core-side request ports and SRAM-side pins of the memory arbiter.
interface risc_mem_arbiter_if #(
    parameter int unsigned DATA_W = risc_pkg::DATA_W_DEF,
    parameter int unsigned ADDR_W = risc_pkg::ADDR_W_DEF
) ();

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_cen;
    logic              mem_wen;
    logic              mem_oen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datain;
    logic [DATA_W-1:0] mem_dataout;

    // Core pipeline plus memory macro: drives requests and read data.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dataout,
        input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
        input  mem_cen, mem_wen, mem_oen, mem_addr, mem_datain
    );

    // Arbiter: accepts requests and drives the memory pins.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dataout,
        output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
        output mem_cen, mem_wen, mem_oen, mem_addr, mem_datain
    );

endinterface

// File: rtl/risc_mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store,
// data first, with a bounded starvation guard for fetch.
module risc_mem_arbiter
    import risc_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    risc_mem_arbiter_if.slave bus
);

    mem_arb_state_t    state;
    port_id_t          owner;
    logic [CNT_W-1:0]  starve_cnt;

    logic              cen_q;
    logic              wen_q;
    logic              oen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_rvalid_q;
    logic              d_rvalid_q;

    logic              slot;
    logic              starved;
    logic              grant_i;
    logic              grant_d;

    // Winner selection; acks are combinational on req within a slot cycle.
    always_comb begin
        slot    = (state == IDLE) || (state == RD_DATA) || (state == WR);
        starved = bus.i_req && (starve_cnt == CNT_W'(STARVE_MAX));
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (slot) begin
            if (starved) begin
                grant_i = 1'b1;
            end else if (bus.d_req) begin
                grant_d = 1'b1;
            end else if (bus.i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // FSM, request latching, memory drive, read completion and starvation count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= PORT_I;
            starve_cnt <= '0;
            cen_q      <= 1'b1;
            wen_q      <= 1'b1;
            oen_q      <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;

            if (state == RD_DATA) begin
                if (owner == PORT_D) begin
                    d_rdata_q  <= bus.mem_dataout;
                    d_rvalid_q <= 1'b1;
                end else begin
                    i_rdata_q  <= bus.mem_dataout;
                    i_rvalid_q <= 1'b1;
                end
            end

            if (grant_d) begin
                owner  <= PORT_D;
                addr_q <= bus.d_addr;
                cen_q  <= 1'b0;
                if (bus.d_we) begin
                    state   <= WR;
                    wen_q   <= 1'b0;
                    oen_q   <= 1'b1;
                    wdata_q <= bus.d_wdata;
                end else begin
                    state <= RD_ADDR;
                    wen_q <= 1'b1;
                    oen_q <= 1'b0;
                end
            end else if (grant_i) begin
                owner  <= PORT_I;
                addr_q <= bus.i_addr;
                state  <= RD_ADDR;
                cen_q  <= 1'b0;
                wen_q  <= 1'b1;
                oen_q  <= 1'b0;
            end else if (state == RD_ADDR) begin
                state <= RD_DATA;
            end else begin
                state <= IDLE;
                cen_q <= 1'b1;
                wen_q <= 1'b1;
                oen_q <= 1'b1;
            end

            if (!bus.i_req || grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d && (starve_cnt != '1)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.i_ack      = grant_i;
    assign bus.d_ack      = grant_d;
    assign bus.i_rvalid   = i_rvalid_q;
    assign bus.d_rvalid   = d_rvalid_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.mem_cen    = cen_q;
    assign bus.mem_wen    = wen_q;
    assign bus.mem_oen    = oen_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_datain = wdata_q;

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Directed bench for risc_mem_arbiter with a behavioural SRAM model.
module tb_risc_mem_arbiter;

    logic clk;
    logic rst_n;

    risc_mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    risc_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: synchronous write when cen/wen low, combinational read.
    logic [31:0] mem [0:2047];
    logic        pl_en;
    logic [10:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!bus.mem_cen && !bus.mem_wen) begin
            mem[bus.mem_addr[10:0]] <= bus.mem_datain;
        end
    end

    assign bus.mem_dataout = mem[bus.mem_addr[10:0]];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [10:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
        tick();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = a;
        @(negedge clk);
        chk({tag, "_ack"}, {31'b0, bus.d_ack}, 32'd1);
        tick();
        bus.d_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk({tag, "_rvalid"}, {31'b0, bus.d_rvalid}, 32'd1);
        chk({tag, "_rdata"}, bus.d_rdata, exp);
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        @(negedge clk);
        chk({tag, "_ack"}, {31'b0, bus.i_ack}, 32'd1);
        tick();
        bus.i_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk({tag, "_rvalid"}, {31'b0, bus.i_rvalid}, 32'd1);
        chk({tag, "_rdata"}, bus.i_rdata, exp);
    endtask

    initial begin
        logic [1:0] exp_grant [0:9];
        int grants;
        int budget;

        rst_n       = 1'b0;
        pl_en       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        preload(11'd5,   32'h1234_5678);
        preload(11'd7,   32'hCAFE_0001);
        preload(11'd100, 32'h0000_0100);
        preload(11'd200, 32'h0000_0200);

        // Reset state.
        @(negedge clk);
        chk("rst_cen",      {31'b0, bus.mem_cen},  32'd1);
        chk("rst_wen",      {31'b0, bus.mem_wen},  32'd1);
        chk("rst_oen",      {31'b0, bus.mem_oen},  32'd1);
        chk("rst_addr",     bus.mem_addr,          32'd0);
        chk("rst_datain",   bus.mem_datain,        32'd0);
        chk("rst_irdata",   bus.i_rdata,           32'd0);
        chk("rst_drdata",   bus.d_rdata,           32'd0);
        chk("rst_rvalid",   {30'b0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
        rst_n = 1'b1;

        // Single fetch with cycle-by-cycle memory drive.
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'd5;
        @(negedge clk);
        chk("f5_iack", {31'b0, bus.i_ack}, 32'd1);
        chk("f5_dack", {31'b0, bus.d_ack}, 32'd0);
        tick();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("f5_c1_oen",  {31'b0, bus.mem_oen}, 32'd0);
        chk("f5_c1_cen",  {31'b0, bus.mem_cen}, 32'd0);
        chk("f5_c1_wen",  {31'b0, bus.mem_wen}, 32'd1);
        chk("f5_c1_addr", bus.mem_addr,         32'd5);
        tick();
        @(negedge clk);
        chk("f5_c2_oen",    {31'b0, bus.mem_oen},  32'd0);
        chk("f5_c2_rvalid", {31'b0, bus.i_rvalid}, 32'd0);
        tick();
        @(negedge clk);
        chk("f5_c3_rvalid", {31'b0, bus.i_rvalid}, 32'd1);
        chk("f5_c3_rdata",  bus.i_rdata,           32'h1234_5678);
        chk("f5_c3_cen",    {31'b0, bus.mem_cen},  32'd1);
        tick();
        @(negedge clk);
        chk("f5_c4_rvalid", {31'b0, bus.i_rvalid}, 32'd0);

        // Store then load back.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'd1026;
        bus.d_wdata = 32'd217;
        @(negedge clk);
        chk("st1026_ack", {31'b0, bus.d_ack}, 32'd1);
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("st1026_wen",    {31'b0, bus.mem_wen}, 32'd0);
        chk("st1026_oen",    {31'b0, bus.mem_oen}, 32'd1);
        chk("st1026_addr",   bus.mem_addr,         32'd1026);
        chk("st1026_datain", bus.mem_datain,       32'd217);
        tick();
        @(negedge clk);
        chk("st1026_wen_off", {31'b0, bus.mem_wen}, 32'd1);
        chk("st1026_rvalid",  {30'b0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
        do_load("ld1026", 32'd1026, 32'd217);

        // Both ports requesting continuously: D,D,D,D,I,D,D,D,D,I.
        for (int k = 0; k < 10; k++) exp_grant[k] = 2'b01;
        exp_grant[4] = 2'b10;
        exp_grant[9] = 2'b10;
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'd100;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'd200;
        grants = 0;
        budget = 0;
        while (grants < 10 && budget < 60) begin
            @(negedge clk);
            budget++;
            if (bus.i_ack || bus.d_ack) begin
                chk($sformatf("grant%0d_ia_da", grants), {30'b0, bus.i_ack, bus.d_ack},
                    {30'b0, exp_grant[grants]});
                grants++;
            end
        end
        chk("grant_count", 32'(grants), 32'd10);
        tick();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (4) tick();

        // Back-to-back stores.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'd512;
        bus.d_wdata = 32'd115;
        @(negedge clk);
        chk("bb0_ack", {31'b0, bus.d_ack}, 32'd1);
        tick();
        bus.d_addr  = 32'd1145;
        bus.d_wdata = 32'd93;
        @(negedge clk);
        chk("bb0_wen",  {31'b0, bus.mem_wen}, 32'd0);
        chk("bb0_addr", bus.mem_addr,         32'd512);
        chk("bb1_ack",  {31'b0, bus.d_ack},   32'd1);
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("bb1_wen",    {31'b0, bus.mem_wen}, 32'd0);
        chk("bb1_addr",   bus.mem_addr,         32'd1145);
        chk("bb1_datain", bus.mem_datain,       32'd93);
        tick();
        @(negedge clk);
        chk("bb_wen_off", {31'b0, bus.mem_wen}, 32'd1);
        do_load("ld512",  32'd512,  32'd115);
        do_load("ld1145", 32'd1145, 32'd93);

        // Reset during RD_DATA of a fetch.
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'd7;
        @(negedge clk);
        chk("rf_ack", {31'b0, bus.i_ack}, 32'd1);
        tick();
        bus.i_req = 1'b0;
        tick();
        #2;
        chk("rf_rddata_oen", {31'b0, bus.mem_oen}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rf_async_cen", {31'b0, bus.mem_cen}, 32'd1);
        chk("rf_async_oen", {31'b0, bus.mem_oen}, 32'd1);
        @(negedge clk);
        chk("rf_rvalid0", {31'b0, bus.i_rvalid}, 32'd0);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rf_rvalid1", {31'b0, bus.i_rvalid}, 32'd0);
        chk("rf_cen_idle", {31'b0, bus.mem_cen}, 32'd1);
        chk("rf_irdata0", bus.i_rdata, 32'd0);
        do_fetch("rf_f7", 32'd7, 32'hCAFE_0001);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/risc_mem_arbiter.md
# risc_mem_arbiter

Two-port arbiter and sequencer that shares one single-port, active-low-controlled SRAM macro (cen/wen/oen) between the RISC core's instruction-fetch port and its load/store port. It sits between the core pipeline and the unified main memory. It converts simple req/ack requests into the memory's one-cycle write and two-cycle read protocol. Data accesses have priority, and a bounded starvation guard protects instruction fetch.

## Interface
Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, word address width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending (1..15)

Ports:
- clk  in  1  system clock; all logic is rising-edge triggered
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held high with i_addr stable until i_ack
- i_addr  in  ADDR_W  fetch word address
- i_ack  out  1  one-cycle pulse: fetch request accepted this cycle
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  DATA_W  fetched word; held until the next fetch completes
- d_req  in  1  data request; d_we, d_addr and d_wdata are held stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only)
- d_rdata  out  DATA_W  loaded word; held until the next load completes
- mem_cen  out  1  memory chip enable, active low
- mem_wen  out  1  memory write enable, active low
- mem_oen  out  1  memory output enable, active low
- mem_addr  out  ADDR_W  memory address
- mem_datain  out  DATA_W  memory write data
- mem_dataout  in  DATA_W  memory read data

## Operation
- FSM states:
  - IDLE: nothing in progress.
  - RD_ADDR: mem_cen=0, mem_oen=0, mem_wen=1, mem_addr = latched address.
  - RD_DATA: same drive as RD_ADDR; mem_dataout is sampled at the end of the cycle.
  - WR: mem_cen=0, mem_wen=0, mem_oen=1, mem_addr and mem_datain = latched values.
- Arbitration slot: any cycle in IDLE, RD_DATA or WR. This allows back-to-back transactions with no bubble.
- Winner selection in a slot:
  - If i_req and the starvation count equals STARVE_MAX, the fetch port wins.
  - Otherwise, if d_req is high, the data port wins.
  - Otherwise, if i_req is high, the fetch port wins.
  - Otherwise there is no grant.
- The winner's ack pulses in the slot cycle. Its address, write data, write flag and port id are latched on that edge.
- Next state after a grant: a store goes to WR; a load or a fetch goes to RD_ADDR. With no grant, next state is IDLE.
- Starvation count (4-bit saturating):
  - Increments on each data grant while i_req is high.
  - Clears on a fetch grant, or in any cycle where i_req is low.
- Completion: on the edge leaving RD_DATA, mem_dataout is registered into the owning port's rdata. That port's rvalid pulses for the following cycle.
- Stores produce no rvalid.
- IDLE drive: mem_cen=1, mem_wen=1, mem_oen=1. mem_addr and mem_datain hold their last values.
- Reset values: state IDLE, all acks and rvalids 0, rdata 0, mem_cen/mem_wen/mem_oen = 1, mem_addr 0, mem_datain 0, starvation count 0.
- Reset mid-transaction: the transaction is abandoned, no rvalid is generated, and the memory is deselected immediately (asynchronously).
- Both ports request simultaneously at STARVE_MAX: the fetch port wins; the data port keeps waiting with its request held.

## Timing
- Load or fetch accepted in cycle N:
  - RD_ADDR in N+1, RD_DATA in N+2.
  - rvalid and rdata in N+3.
  - The next grant can ack in N+2.
- Store accepted in cycle N: WR in N+1, write committed at the end of N+1; the next grant can ack in N+1.
- Sustained loads give 1 word every 2 cycles; sustained stores give 1 word per cycle.
- ack is Mealy on req within a slot. Requesters must not change request fields in the ack cycle before the clock edge.

## Structure
- Shared package risc_pkg holds:
  - DATA_W and ADDR_W defaults
  - the state encoding mem_arb_state_t (IDLE, RD_ADDR, RD_DATA, WR)
  - the port-id constants PORT_I and PORT_D
- Single module; no sub-module. The starvation counter and winner logic are small enough to live inline.

## Test plan
- Reset, then a single fetch i_addr=5 with memory preloaded M[5]=0x12345678: i_ack in cycle 0; mem_oen=0 in cycles 1–2; i_rvalid with i_rdata=0x12345678 in cycle 3.
- Store d_addr=1026, d_wdata=217, then load d_addr=1026: mem_wen=0 for exactly one cycle with addr 1026; the load returns d_rdata=217 three cycles after its ack.
- i_req and d_req held high continuously, with loads on the data side and STARVE_MAX=4: the grant sequence is D,D,D,D,I,D,D,D,D,I.
- Back-to-back stores to 512 and 1145: WR occupies consecutive cycles, with d_ack on each; reading back gives 115 and 93.
- rst_n pulled low during RD_DATA of a fetch: mem_cen/mem_oen return to 1 immediately; no i_rvalid; after release the FSM is in IDLE and a new fetch completes normally.
